// File: rtl/sr_flipflop_guard.sv
// Clocked guard for an active-low S/R pair: sync, deglitch, decode, registered Q/Q_bar with INVALID flagging.
// Optional glitch counter port glt_cnt enabled by defining SR_GUARD_GLITCH_CNT_EN.
module sr_flipflop_guard #(
  parameter int FILT_LEN     = 2,
  parameter int CNT_W        = 8,
  parameter int INVALID_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_n,
  input  logic             r_n,
  input  logic             clr_err,
`ifdef SR_GUARD_GLITCH_CNT_EN
  output logic [CNT_W-1:0] glt_cnt,
`endif
  output logic             q,
  output logic             q_bar,
  output logic             invalid,
  output logic             err_sticky,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt,
  output logic [CNT_W-1:0] inv_cnt
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_SET  = 2'd1,
    ST_RST  = 2'd2,
    ST_INV  = 2'd3
  } state_t;

  localparam logic [3:0] FL4 = FILT_LEN[3:0];

  logic       r_s_meta, r_s_sync, r_r_meta, r_r_sync;
  state_t     r_cand, r_state, w_cand;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       w_same, w_accept, w_enter;
  logic       r_q, r_invalid, r_err;
  logic [CNT_W-1:0] r_set_cnt, r_rst_cnt, r_inv_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_meta <= 1'b1;
      r_s_sync <= 1'b1;
      r_r_meta <= 1'b1;
      r_r_sync <= 1'b1;
    end else begin
      r_s_meta <= s_n;
      r_s_sync <= r_s_meta;
      r_r_meta <= r_n;
      r_r_sync <= r_r_meta;
    end
  end

  always_comb begin
    w_cand = ST_INV;
    case ({r_s_sync, r_r_sync})
      2'b10:   w_cand = ST_RST;
      2'b01:   w_cand = ST_SET;
      2'b11:   w_cand = ST_HOLD;
      default: w_cand = ST_INV;
    endcase
  end

  // Run length saturates at FILT_LEN; a stable command keeps re-accepting, which is a no-op.
  assign w_same    = (w_cand == r_cand);
  assign w_cnt_nxt = !w_same ? 4'd1 : ((r_cnt == FL4) ? r_cnt : r_cnt + 4'd1);
  assign w_accept  = (w_cnt_nxt == FL4);
  assign w_enter   = w_accept && (w_cand != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= ST_HOLD;
      r_cnt  <= 4'd0;
    end else begin
      r_cand <= w_cand;
      r_cnt  <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_HOLD;
      r_q       <= 1'b0;
      r_invalid <= 1'b0;
      r_err     <= 1'b0;
      r_set_cnt <= '0;
      r_rst_cnt <= '0;
      r_inv_cnt <= '0;
    end else begin
      r_invalid <= 1'b0;
      if (clr_err) r_err <= 1'b0;
      if (w_enter) begin
        r_state <= w_cand;
        case (w_cand)
          ST_SET: begin
            r_q       <= 1'b1;
            r_set_cnt <= sat_inc(r_set_cnt);
          end
          ST_RST: begin
            r_q       <= 1'b0;
            r_rst_cnt <= sat_inc(r_rst_cnt);
          end
          ST_INV: begin
            if (INVALID_MODE == 1)      r_q <= 1'b0;
            else if (INVALID_MODE == 2) r_q <= 1'b1;
            r_invalid <= 1'b1;
            r_err     <= 1'b1;
            r_inv_cnt <= sat_inc(r_inv_cnt);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SR_GUARD_GLITCH_CNT_EN
  logic             w_drop;
  logic [CNT_W-1:0] r_glt_cnt;

  // A candidate that never reached FILT_LEN and would have changed state was a glitch.
  assign w_drop = !w_same && (r_cnt != 4'd0) && (r_cnt < FL4) && (r_cand != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_glt_cnt <= '0;
    else if (w_drop) r_glt_cnt <= sat_inc(r_glt_cnt);
  end

  assign glt_cnt = r_glt_cnt;
`endif

  assign q          = r_q;
  assign q_bar      = ~r_q;
  assign invalid    = r_invalid;
  assign err_sticky = r_err;
  assign set_cnt    = r_set_cnt;
  assign rst_cnt    = r_rst_cnt;
  assign inv_cnt    = r_inv_cnt;

endmodule

// File: tb/tb_sr_flipflop_guard.sv
// Bench for sr_flipflop_guard: four parameter sets driven by one stimulus, checked against an input-history model.
module tb_sr_flipflop_guard;

  localparam int NCFG = 4;
  localparam int HLEN = 20;

  function automatic int cfg_fl(input int g); return (g == 3) ? 3 : 2; endfunction
  function automatic int cfg_im(input int g); return (g == 1) ? 1 : ((g == 3) ? 2 : 0); endfunction
  function automatic int cfg_cw(input int g); return (g == 2) ? 2 : 8; endfunction

  logic clk = 1'b0;
  logic rst_n, s_n, r_n, clr_err;
  always #5 clk = ~clk;

  logic       d_q[NCFG], d_qb[NCFG], d_inv[NCFG], d_err[NCFG];
  logic [7:0] d_set[NCFG], d_rst[NCFG], d_ic[NCFG], d_glt[NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int FL = cfg_fl(g);
    localparam int IM = cfg_im(g);
    localparam int CW = cfg_cw(g);
    logic w_q, w_qb, w_inv, w_err;
    logic [CW-1:0] w_set, w_rst, w_ic, w_glt;
    sr_flipflop_guard #(.FILT_LEN(FL), .CNT_W(CW), .INVALID_MODE(IM)) u_dut (
`ifdef SR_GUARD_GLITCH_CNT_EN
      .glt_cnt(w_glt),
`endif
      .clk(clk), .rst_n(rst_n), .s_n(s_n), .r_n(r_n), .clr_err(clr_err),
      .q(w_q), .q_bar(w_qb), .invalid(w_inv), .err_sticky(w_err),
      .set_cnt(w_set), .rst_cnt(w_rst), .inv_cnt(w_ic)
    );
`ifndef SR_GUARD_GLITCH_CNT_EN
    assign w_glt = '0;
`endif
    assign d_q[g]   = w_q;
    assign d_qb[g]  = w_qb;
    assign d_inv[g] = w_inv;
    assign d_err[g] = w_err;
    assign d_set[g] = 8'(w_set);
    assign d_rst[g] = 8'(w_rst);
    assign d_ic[g]  = 8'(w_ic);
    assign d_glt[g] = 8'(w_glt);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0 HOLD, 1 SET, 2 RST, 3 INV. A command is accepted once the last FILT_LEN
  // input samples that have crossed the two-stage synchronizer all agree.
  logic [1:0] hist[HLEN];
  int m_st[NCFG], m_q[NCFG], m_inv[NCFG], m_err[NCFG];
  int m_set[NCFG], m_rst[NCFG], m_ic[NCFG], m_glt[NCFG];

  function automatic int dec(input logic [1:0] p);
    case (p)
      2'b10:   return 2;
      2'b01:   return 1;
      2'b11:   return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int sat(input int v, input int cw);
    return (v >= (1 << cw) - 1) ? v : v + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HLEN; i++) hist[i] = 2'b11;
      for (int g = 0; g < NCFG; g++) begin
        m_st[g] = 0; m_q[g] = 0; m_inv[g] = 0; m_err[g] = 0;
        m_set[g] = 0; m_rst[g] = 0; m_ic[g] = 0; m_glt[g] = 0;
      end
    end else begin
      for (int g = 0; g < NCFG; g++) begin
        int fl, cw, cmd, run;
        bit stable;
        fl = cfg_fl(g);
        cw = cfg_cw(g);
        stable = 1'b1;
        for (int k = 2; k <= fl; k++) if (hist[k] != hist[1]) stable = 1'b0;
        cmd = dec(hist[1]);
        if (hist[1] != hist[2]) begin
          run = 0;
          for (int k = 2; k < HLEN; k++) begin
            if (hist[k] != hist[2]) break;
            run++;
          end
          if (run < fl && dec(hist[2]) != m_st[g]) m_glt[g] = sat(m_glt[g], cw);
        end
        m_inv[g] = 0;
        if (clr_err) m_err[g] = 0;
        if (stable && cmd != m_st[g]) begin
          m_st[g] = cmd;
          if (cmd == 1) begin
            m_q[g] = 1; m_set[g] = sat(m_set[g], cw);
          end else if (cmd == 2) begin
            m_q[g] = 0; m_rst[g] = sat(m_rst[g], cw);
          end else if (cmd == 3) begin
            if (cfg_im(g) == 1) m_q[g] = 0;
            if (cfg_im(g) == 2) m_q[g] = 1;
            m_inv[g] = 1; m_err[g] = 1; m_ic[g] = sat(m_ic[g], cw);
          end
        end
      end
      for (int i = HLEN - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {s_n, r_n};
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("c%0d q", g),          int'(d_q[g]),   m_q[g]);
      chk($sformatf("c%0d q_bar", g),      int'(d_qb[g]),  1 - m_q[g]);
      chk($sformatf("c%0d invalid", g),    int'(d_inv[g]), m_inv[g]);
      chk($sformatf("c%0d err_sticky", g), int'(d_err[g]), m_err[g]);
      chk($sformatf("c%0d set_cnt", g),    int'(d_set[g]), m_set[g]);
      chk($sformatf("c%0d rst_cnt", g),    int'(d_rst[g]), m_rst[g]);
      chk($sformatf("c%0d inv_cnt", g),    int'(d_ic[g]),  m_ic[g]);
`ifdef SR_GUARD_GLITCH_CNT_EN
      chk($sformatf("c%0d glt_cnt", g),    int'(d_glt[g]), m_glt[g]);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input int n);
    s_n = s;
    r_n = r;
    step(n);
  endtask

  initial begin
    rst_n = 1'b0; s_n = 1'b1; r_n = 1'b1; clr_err = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(10);
    chk("idle q", int'(d_q[0]), 0);
    chk("idle q_bar", int'(d_qb[0]), 1);
    chk("idle set_cnt", int'(d_set[0]), 0);

    drive(1'b0, 1'b1, 3);
    chk("set edge3 q", int'(d_q[0]), 0);
    step(1);
    chk("set edge4 q", int'(d_q[0]), 1);
    chk("set edge4 set_cnt", int'(d_set[0]), 1);
    step(22);
    chk("set held set_cnt", int'(d_set[0]), 1);

    drive(1'b1, 1'b1, 6);
    drive(1'b0, 1'b0, 3);
    chk("inv edge3 invalid", int'(d_inv[0]), 0);
    step(1);
    chk("inv hold-mode q", int'(d_q[0]), 1);
    chk("inv reset-mode q", int'(d_q[1]), 0);
    chk("inv pulse", int'(d_inv[0]), 1);
    chk("inv err_sticky", int'(d_err[0]), 1);
    chk("inv inv_cnt", int'(d_ic[0]), 1);
    step(1);
    chk("inv pulse ends", int'(d_inv[0]), 0);
    step(2);

    drive(1'b1, 1'b1, 6);
    drive(1'b0, 1'b0, 3);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("clr vs set err", int'(d_err[0]), 1);
    chk("clr inv_cnt", int'(d_ic[0]), 2);
    step(2);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("clr err", int'(d_err[0]), 0);

    drive(1'b1, 1'b1, 6);
    drive(1'b1, 1'b0, 6);
    chk("reset q", int'(d_q[0]), 0);
    chk("reset rst_cnt", int'(d_rst[0]), 1);
    drive(1'b1, 1'b1, 6);
    drive(1'b0, 1'b1, 1);
    drive(1'b1, 1'b1, 6);
    chk("glitch q", int'(d_q[0]), 0);
    chk("glitch set_cnt", int'(d_set[0]), 1);
`ifdef SR_GUARD_GLITCH_CNT_EN
    chk("glitch glt_cnt", int'(d_glt[0]), 1);
`endif

    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 6);
      drive(1'b1, 1'b0, 6);
    end
    chk("sat set_cnt", int'(d_set[2]), 3);
    chk("sat rst_cnt", int'(d_rst[2]), 3);
    chk("wide set_cnt", int'(d_set[0]), 6);
    chk("wide rst_cnt", int'(d_rst[0]), 6);

    drive(1'b0, 1'b1, 5);
    chk("pre-reset q", int'(d_q[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset q", int'(d_q[0]), 0);
    chk("async reset q_bar", int'(d_qb[0]), 1);
    chk("async reset set_cnt", int'(d_set[2]), 0);
    chk("async reset inv_cnt", int'(d_ic[0]), 0);
    chk("async reset err", int'(d_err[0]), 0);
    step(2);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 10);
    chk("post reset q", int'(d_q[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_flipflop_guard.md
Name: sr_flipflop_guard

Overview:
- Synthesizable clocked consumer of the active-low S/R command pair that the team's SR latch benches drive.
- Synchronizes and deglitches s_n/r_n, then decodes them into SET, RESET, HOLD or INVALID.
- Drives a registered Q/Q_bar pair that can never enter the invalid (both-high) output state.
- Flags and counts illegal S=R=0 requests instead of letting them race or hang.

Parameters:
- FILT_LEN, 2: number of consecutive synchronized cycles a command must be stable before it is accepted; legal range 1..15.
- CNT_W, 8: width of the event counters.
- INVALID_MODE, 0: q policy on accepted INVALID; 0 = hold, 1 = reset-dominant (q=0), 2 = set-dominant (q=1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_n  input  1  active-low set request; asynchronous to clk.
- r_n  input  1  active-low reset request; asynchronous to clk.
- clr_err  input  1  synchronous clear of err_sticky.
- q  output  1  registered state.
- q_bar  output  1  always ~q.
- invalid  output  1  one-cycle pulse on entry to INVALID.
- err_sticky  output  1  set on entry to INVALID; held until clr_err.
- set_cnt  output  CNT_W  accepted SET entries, saturating.
- rst_cnt  output  CNT_W  accepted RESET entries, saturating.
- inv_cnt  output  CNT_W  accepted INVALID entries, saturating.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-style release at the next clk edge):
  - q=0, q_bar=1, invalid=0, err_sticky=0, all counters 0.
  - Both synchronizer stages = 1 (idle), filter count 0, FSM state HOLD.
  - Reset asserted mid-filter or while in INVALID discards all pending state.
- Synchronizer: two flops per input. Decode of the stage-2 pair {s_n, r_n}: 10 = RESET, 01 = SET, 11 = HOLD, 00 = INVALID.
- Filter:
  - Candidate = current decode. The count restarts at 1 whenever the candidate differs from the previous cycle.
  - The command is accepted on the edge where the count reaches FILT_LEN.
  - A candidate that changes before acceptance is dropped silently.
- FSM states: HOLD, SET, RST, INV. The state moves only on acceptance of a command different from the current state; re-acceptance of the same command is a no-op.
  - Entry to SET: q<=1, set_cnt+1.
  - Entry to RST: q<=0, rst_cnt+1.
  - Entry to HOLD: q unchanged.
  - Entry to INV: q per INVALID_MODE, invalid=1 for exactly that cycle, err_sticky<=1, inv_cnt+1.
  - INV->HOLD keeps the q value held in INV. INV->SET and INV->RST behave as normal entries.
- Latency: first edge that samples the new input level = edge 1; q/flags/counters reflect the accepted command after edge 2+FILT_LEN (edge 4 for default).
- Counters saturate at 2^CNT_W-1 and never wrap.
- err_sticky: clr_err clears it at the next edge. Simultaneous INV entry and clr_err leaves err_sticky=1 (set wins).
- q_bar is the complement of q at all times, including during reset.

Optional Feature:
- SR_GUARD_GLITCH_CNT_EN defined: adds output port glt_cnt [CNT_W-1:0], reset 0, saturating. It increments once per candidate dropped before reaching FILT_LEN, excluding a candidate equal to the current FSM state.
- Undefined: port and logic absent; dropped candidates are not recorded.

Test Plan:
- Reset then idle (s_n=1, r_n=1) for 10 cycles -> q=0, q_bar=1, all counters 0, invalid never pulses.
- s_n=0,r_n=1 held 6 cycles starting before edge 1 -> q=1 after edge 4, set_cnt=1; hold 20 more cycles -> set_cnt stays 1.
- s_n=0,r_n=0 held 6 cycles with INVALID_MODE=0, q=1 -> q stays 1, invalid high one cycle, err_sticky=1, inv_cnt=1; repeat with INVALID_MODE=1 -> q=0.
- Drive 00 and hold, then pulse clr_err in the same cycle as INV entry -> err_sticky=1. Pulse clr_err again 3 cycles later -> err_sticky=0 next edge.
- s_n=0 for 1 clk cycle with FILT_LEN=2 -> q unchanged, set_cnt=0; with SR_GUARD_GLITCH_CNT_EN -> glt_cnt=1.
- CNT_W=2, toggle SET/RESET 5 times each -> set_cnt=3 and rst_cnt=3 (saturated). Assert rst_n mid-sequence -> all outputs return to reset values immediately.
